// File: rtl/c1_bus_arbiter.sv
// c1_bus_arbiter: round-robin arbiter and C1 bus sequencer for two requesters.
// It latches a whole transaction from one requester at a time, drives the
// two-tick address phase, releases the bus and collects the C1 response.
module c1_bus_arbiter #(
   parameter int ADDR1_W = 15,
   parameter int DATA1_W = 16,
   parameter int CTR1_W  = 3,
   parameter int TIMEOUT = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 req_valid,
   input  logic [2*CTR1_W-1:0]        req_cmd,
   input  logic [2*(ADDR1_W+4)-1:0]   req_addr,
   input  logic [4*DATA1_W-1:0]       req_wdata,
   output logic [1:0]                 req_ready,
   output logic [1:0]                 rsp_valid,
   output logic [2*DATA1_W-1:0]       rsp_rdata,
   output logic                       rsp_err,
   output logic [ADDR1_W-1:0]         a1_out,
   output logic [CTR1_W-1:0]          c1_out,
   output logic                       c1_oe,
   input  logic [CTR1_W-1:0]          c1_in,
   output logic [DATA1_W-1:0]         d1_out,
   output logic                       d1_oe,
   input  logic [DATA1_W-1:0]         d1_in
);

   localparam int AW    = ADDR1_W + 4;
   localparam int WW    = 2 * DATA1_W;
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [CTR1_W-1:0] C1_NOP      = CTR1_W'(0);
   localparam logic [CTR1_W-1:0] C1_READ8    = CTR1_W'(1);
   localparam logic [CTR1_W-1:0] C1_READ16   = CTR1_W'(2);
   localparam logic [CTR1_W-1:0] C1_READ32   = CTR1_W'(3);
   localparam logic [CTR1_W-1:0] C1_INVAL    = CTR1_W'(4);
   localparam logic [CTR1_W-1:0] C1_WRITE8   = CTR1_W'(5);
   localparam logic [CTR1_W-1:0] C1_WRITE32  = CTR1_W'(7);
   localparam logic [CTR1_W-1:0] C1_RESPONSE = CTR1_W'(7);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR1, S_ADDR2, S_WAIT, S_RD2, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               bus_en_q;
   logic               last_q;
   logic               id_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q;
   logic [ADDR1_W-1:0] a1_q;
   logic [CTR1_W-1:0]  cmd_q;
   logic [3:0]         off_q;
   logic [WW-1:0]      wdata_q;
   logic [WW-1:0]      rdata_q;

   logic               win;
   logic [CTR1_W-1:0]  sel_cmd;
   logic [AW-1:0]      sel_addr;
   logic [WW-1:0]      sel_wdata;
   logic               rsp_hit;
   logic               tmo_hit;
   logic               is_wr;
   logic [DATA1_W-1:0] wr_lo;

   // Winner selection: alternate when both ask, otherwise take whoever asks.
   always_comb begin
      win       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
      sel_cmd   = win ? req_cmd[2*CTR1_W-1:CTR1_W] : req_cmd[CTR1_W-1:0];
      sel_addr  = win ? req_addr[2*AW-1:AW]        : req_addr[AW-1:0];
      sel_wdata = win ? req_wdata[2*WW-1:WW]       : req_wdata[WW-1:0];
      rsp_hit   = (c1_in == C1_RESPONSE);
      tmo_hit   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
      is_wr     = (cmd_q >= C1_WRITE8);
      wr_lo     = (cmd_q == C1_WRITE8) ? {{(DATA1_W-8){1'b0}}, wdata_q[7:0]}
                                       : wdata_q[DATA1_W-1:0];
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a response beats a timeout on the same edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (|req_valid) state_d = S_ADDR1;
         S_ADDR1: state_d = (cmd_q == C1_INVAL) ? S_WAIT : S_ADDR2;
         S_ADDR2: state_d = S_WAIT;
         S_WAIT: begin
            if (rsp_hit)      state_d = (cmd_q == C1_READ32) ? S_RD2 : S_DONE;
            else if (tmo_hit) state_d = S_DONE;
         end
         S_RD2:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers: grant history, owner id, timeout counter, error flag, address bus.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_en_q <= 1'b0;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         a1_q     <= '0;
      end else begin
         bus_en_q <= 1'b1;
         cnt_q    <= '0;
         case (state_q)
            S_IDLE: begin
               if (|req_valid) begin
                  id_q   <= win;
                  last_q <= win;
                  err_q  <= 1'b0;
                  a1_q   <= sel_addr[AW-1:4];
               end
            end
            S_ADDR1: begin
               if (cmd_q != C1_INVAL) a1_q <= {{(ADDR1_W-4){1'b0}}, off_q};
            end
            S_WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (!rsp_hit && tmo_hit) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Transaction payload and read-data assembly; no reset needed on data.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && (|req_valid)) begin
         cmd_q   <= sel_cmd;
         off_q   <= sel_addr[3:0];
         wdata_q <= sel_wdata;
      end
      if (state_q == S_WAIT) begin
         if (rsp_hit) begin
            case (cmd_q)
               C1_READ8:  rdata_q <= {{(WW-8){1'b0}}, d1_in[7:0]};
               C1_READ16: rdata_q <= {{DATA1_W{1'b0}}, d1_in};
               C1_READ32: rdata_q <= {{DATA1_W{1'b0}}, d1_in};
               default:   rdata_q <= '0;
            endcase
         end else if (tmo_hit) begin
            rdata_q <= '0;
         end
      end
      if (state_q == S_RD2) rdata_q[WW-1:DATA1_W] <= d1_in;
   end

   // Bus and handshake outputs decoded from the current state.
   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      rsp_err   = 1'b0;
      c1_out    = C1_NOP;
      c1_oe     = 1'b0;
      d1_out    = '0;
      d1_oe     = 1'b0;
      case (state_q)
         S_IDLE: c1_oe = bus_en_q;
         S_ADDR1: begin
            req_ready = id_q ? 2'b10 : 2'b01;
            c1_oe     = 1'b1;
            c1_out    = cmd_q;
            d1_oe     = is_wr;
            if (is_wr) d1_out = wr_lo;
         end
         S_ADDR2: begin
            c1_oe  = 1'b1;
            c1_out = cmd_q;
            d1_oe  = is_wr;
            if (is_wr) d1_out = (cmd_q == C1_WRITE32) ? wdata_q[WW-1:DATA1_W] : wr_lo;
         end
         S_DONE: begin
            rsp_valid = id_q ? 2'b10 : 2'b01;
            rsp_err   = err_q;
         end
         default: ;
      endcase
   end

   assign a1_out    = a1_q;
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_c1_bus_arbiter.sv
// Directed bench for c1_bus_arbiter with hand-computed expectations.
module tb_c1_bus_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [5:0]  req_cmd;
   logic [37:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [14:0] a1_out;
   logic [2:0]  c1_out;
   logic        c1_oe;
   logic [2:0]  c1_in;
   logic [15:0] d1_out;
   logic        d1_oe;
   logic [15:0] d1_in;

   int nchk = 0;
   int nfail = 0;

   c1_bus_arbiter #(.ADDR1_W(15), .DATA1_W(16), .CTR1_W(3), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .a1_out(a1_out), .c1_out(c1_out), .c1_oe(c1_oe), .c1_in(c1_in),
      .d1_out(d1_out), .d1_oe(d1_oe), .d1_in(d1_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] cmd, input logic [18:0] addr,
                          input logic [31:0] wd);
      req_cmd[i*3 +: 3]     = cmd;
      req_addr[i*19 +: 19]  = addr;
      req_wdata[i*32 +: 32] = wd;
   endtask

   logic [1:0] exp_oh [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; req_cmd = '0; req_addr = '0; req_wdata = '0;
      c1_in = 3'd0; d1_in = 16'd0;
      tick(); tick();
      chk("rst_c1_oe", c1_oe, 1'b0);
      chk("rst_d1_oe", d1_oe, 1'b0);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_a1", a1_out, 15'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_c1_oe", c1_oe, 1'b1);
      chk("idle_c1_nop", c1_out, 3'd0);

      // READ8 from requester 0 at 0x00013
      set_req(0, 3'd1, 19'h00013, 32'h0); req_valid = 2'b01;
      tick();
      chk("r8_ready", req_ready, 2'b01);
      chk("r8_a1_tick1", a1_out, 15'h0001);
      chk("r8_c1_tick1", c1_out, 3'd1);
      chk("r8_d1_oe", d1_oe, 1'b0);
      req_valid = 2'b00;
      tick();
      chk("r8_a1_tick2", a1_out, 15'h0003);
      chk("r8_ready_pulse", req_ready, 2'b00);
      tick();
      chk("r8_release", c1_oe, 1'b0);
      tick(); tick();
      c1_in = 3'd7; d1_in = 16'h01AB;
      tick();
      c1_in = 3'd0; d1_in = 16'h0;
      chk("r8_rsp_valid", rsp_valid, 2'b01);
      chk("r8_rdata", rsp_rdata, 32'h000000AB);
      chk("r8_err", rsp_err, 1'b0);
      tick();
      chk("r8_back_idle", rsp_valid, 2'b00);
      chk("r8_idle_oe", c1_oe, 1'b1);

      // WRITE32 0xDEADBEEF from requester 1 at 0x00100
      set_req(1, 3'd7, 19'h00100, 32'hDEADBEEF); req_valid = 2'b10;
      tick();
      chk("w32_ready", req_ready, 2'b10);
      chk("w32_c1", c1_out, 3'd7);
      chk("w32_d1_oe", d1_oe, 1'b1);
      chk("w32_d1_lo", d1_out, 16'hBEEF);
      chk("w32_a1_tick1", a1_out, 15'h0010);
      req_valid = 2'b00;
      tick();
      chk("w32_d1_hi", d1_out, 16'hDEAD);
      chk("w32_c1_tick2", c1_out, 3'd7);
      chk("w32_a1_tick2", a1_out, 15'h0000);
      tick();
      chk("w32_wait_d1_oe", d1_oe, 1'b0);
      chk("w32_wait_c1_oe", c1_oe, 1'b0);
      c1_in = 3'd7; d1_in = 16'hFFFF;
      tick();
      c1_in = 3'd0; d1_in = 16'h0;
      chk("w32_rsp_valid", rsp_valid, 2'b10);
      chk("w32_rdata", rsp_rdata, 32'h0);
      tick();

      // READ32 from requester 0 at 0x12345
      set_req(0, 3'd3, 19'h12345, 32'h0); req_valid = 2'b01;
      tick();
      chk("r32_a1_tick1", a1_out, 15'h1234);
      req_valid = 2'b00;
      tick();
      chk("r32_a1_tick2", a1_out, 15'h0005);
      tick();
      c1_in = 3'd7; d1_in = 16'h5678;
      tick();
      chk("r32_rd2_no_rsp", rsp_valid, 2'b00);
      c1_in = 3'd0; d1_in = 16'h1234;
      tick();
      d1_in = 16'h0;
      chk("r32_rsp_valid", rsp_valid, 2'b01);
      chk("r32_rdata", rsp_rdata, 32'h12345678);
      tick();

      // WRITE8 from requester 1: only the low byte goes out, zero-extended
      set_req(1, 3'd5, 19'h00007, 32'h123456A5); req_valid = 2'b10;
      tick();
      chk("w8_d1_tick1", d1_out, 16'h00A5);
      req_valid = 2'b00;
      tick();
      chk("w8_d1_tick2", d1_out, 16'h00A5);
      chk("w8_d1_oe", d1_oe, 1'b1);
      tick();
      c1_in = 3'd7;
      tick();
      c1_in = 3'd0;
      chk("w8_rsp_valid", rsp_valid, 2'b10);
      tick();

      // Both requesters asking continuously: READ16 each, grants alternate 0,1,0,1
      set_req(0, 3'd2, 19'h00040, 32'h0);
      set_req(1, 3'd2, 19'h00050, 32'h0);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_ready", req_ready, exp_oh[k]);
         tick(); tick();
         c1_in = 3'd7; d1_in = 16'h8000 + 16'(k);
         tick();
         c1_in = 3'd0; d1_in = 16'h0;
         chk("rr_rsp_valid", rsp_valid, exp_oh[k]);
         chk("rr_rdata", rsp_rdata, 32'h00008000 + 32'(k));
         tick();
         chk("rr_idle_nop_oe", c1_oe, 1'b1);
         chk("rr_idle_nop_cmd", c1_out, 3'd0);
         chk("rr_idle_no_ready", req_ready, 2'b00);
      end
      req_valid = 2'b00;

      // INVALIDATE with no response: single address tick, timeout after 8 WAIT cycles
      set_req(0, 3'd4, 19'h00AB0, 32'h0); req_valid = 2'b01;
      tick();
      chk("inv_c1", c1_out, 3'd4);
      chk("inv_a1", a1_out, 15'h00AB);
      req_valid = 2'b00;
      tick();
      chk("inv_single_tick", c1_oe, 1'b0);
      chk("inv_a1_hold", a1_out, 15'h00AB);
      for (int k = 0; k < 7; k++) tick();
      chk("inv_no_early_rsp", rsp_valid, 2'b00);
      tick();
      chk("inv_tmo_valid", rsp_valid, 2'b01);
      chk("inv_tmo_err", rsp_err, 1'b1);
      chk("inv_tmo_rdata", rsp_rdata, 32'h0);
      tick();
      chk("inv_err_clear", rsp_err, 1'b0);

      // Same, but the response lands on the 8th WAIT cycle and beats the timeout
      set_req(0, 3'd4, 19'h00AB0, 32'h0); req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick();
      for (int k = 0; k < 7; k++) tick();
      c1_in = 3'd7;
      tick();
      c1_in = 3'd0;
      chk("inv_race_valid", rsp_valid, 2'b01);
      chk("inv_race_err", rsp_err, 1'b0);
      tick();

      // Reset in WAIT of a READ16 from requester 0 drops it and restores grant priority
      set_req(0, 3'd2, 19'h00020, 32'h0); req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      tick(); tick(); tick();
      rst_n = 1'b0; c1_in = 3'd7; d1_in = 16'h1111;
      tick();
      chk("mid_rst_c1_oe", c1_oe, 1'b0);
      chk("mid_rst_d1_oe", d1_oe, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
      chk("mid_rst_a1", a1_out, 15'd0);
      rst_n = 1'b1; c1_in = 3'd0; d1_in = 16'h0;
      tick();
      chk("post_rst_no_rsp", rsp_valid, 2'b00);
      chk("post_rst_idle_oe", c1_oe, 1'b1);
      set_req(0, 3'd1, 19'h00030, 32'h0);
      set_req(1, 3'd1, 19'h00060, 32'h0);
      req_valid = 2'b11;
      tick();
      chk("post_rst_grant0", req_ready, 2'b01);
      req_valid = 2'b00;
      tick(); tick();
      c1_in = 3'd7; d1_in = 16'h0042;
      tick();
      c1_in = 3'd0; d1_in = 16'h0;
      chk("post_rst_rsp", rsp_valid, 2'b01);
      chk("post_rst_rdata", rsp_rdata, 32'h00000042);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
